cache_ri_refill: RTL and testbench



---
 rtl/cache_ri_refill.sv | 156 +++++++++++++++
 tb/tb_cache_ri_refill.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ri_refill.sv
// Data-cache line refill engine: reads a line's readable-byte mask, fetches only the
// words that are not fully readable, merges the missing bytes and marks the line readable.
module cache_ri_refill #(
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-2:0] req_line,
    input  logic [1:0]            req_channel,
    input  logic [31:0]           req_memAddress,
    output logic                  busy,
    output logic [ADDR_WIDTH-1:0] ri_readAddress,
    output logic [1:0]            ri_readChannel,
    input  logic [7:0]            ri_readData,
    output logic [ADDR_WIDTH-1:0] ri_writeAddress,
    output logic [1:0]            ri_writeChannel,
    output logic                  ri_writeEnable,
    output logic [7:0]            ri_writeData,
    output logic [ADDR_WIDTH-1:0] dat_writeAddress,
    output logic [1:0]            dat_writeChannel,
    output logic [31:0]           dat_writeData,
    output logic [3:0]            dat_writeByteEnable,
    output logic                  dat_writeEnable,
    output logic [31:0]           mem_address,
    output logic                  mem_read,
    input  logic                  mem_waitRequest,
    input  logic [31:0]           mem_readData,
    input  logic                  mem_readDataValid,
    output logic                  done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_DRE_RD,
        S_DRE_CAP,
        S_CHECK,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_DAT_WR,
        S_UPD_DRE,
        S_DONE
    } state_t;

    state_t                state;
    logic [ADDR_WIDTH-2:0] line_q;
    logic [31:0]           base_q;
    logic                  word_q;
    logic [7:0]            mask_q;
    logic [3:0]            nib;

    // Readable flags of the word currently being considered
    assign nib       = word_q ? mask_q[7:4] : mask_q[3:0];
    assign req_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    // Outputs are registered on entry to the state that owns them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state               <= S_IDLE;
            line_q              <= '0;
            base_q              <= '0;
            word_q              <= 1'b0;
            mask_q              <= '0;
            ri_readAddress      <= '0;
            ri_readChannel      <= '0;
            ri_writeAddress     <= '0;
            ri_writeChannel     <= '0;
            ri_writeEnable      <= 1'b0;
            ri_writeData        <= '0;
            dat_writeAddress    <= '0;
            dat_writeChannel    <= '0;
            dat_writeData       <= '0;
            dat_writeByteEnable <= '0;
            dat_writeEnable     <= 1'b0;
            mem_address         <= '0;
            mem_read            <= 1'b0;
            done                <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        line_q           <= req_line;
                        base_q           <= req_memAddress;
                        word_q           <= 1'b0;
                        ri_readAddress   <= {req_line, 1'b0};
                        ri_readChannel   <= req_channel;
                        ri_writeAddress  <= {req_line, 1'b0};
                        ri_writeChannel  <= req_channel;
                        dat_writeChannel <= req_channel;
                        state            <= S_DRE_RD;
                    end
                end
                S_DRE_RD: state <= S_DRE_CAP;
                S_DRE_CAP: begin
                    mask_q <= ri_readData;
                    state  <= S_CHECK;
                end
                S_CHECK: begin
                    if (nib == 4'hF) begin
                        if (word_q) begin
                            ri_writeEnable <= 1'b1;
                            ri_writeData   <= 8'hFF;
                            state          <= S_UPD_DRE;
                        end else begin
                            word_q <= 1'b1;
                        end
                    end else begin
                        mem_read    <= 1'b1;
                        mem_address <= base_q + {29'd0, word_q, 2'b00};
                        state       <= S_MEM_REQ;
                    end
                end
                S_MEM_REQ: begin
                    if (!mem_waitRequest) begin
                        mem_read <= 1'b0;
                        state    <= S_MEM_WAIT;
                    end
                end
                // Only bytes not already readable are written, preserving CPU stores
                S_MEM_WAIT: begin
                    if (mem_readDataValid) begin
                        dat_writeData       <= mem_readData;
                        dat_writeAddress    <= {line_q, word_q};
                        dat_writeByteEnable <= ~nib;
                        dat_writeEnable     <= 1'b1;
                        state               <= S_DAT_WR;
                    end
                end
                S_DAT_WR: begin
                    dat_writeEnable <= 1'b0;
                    if (word_q) begin
                        ri_writeEnable <= 1'b1;
                        ri_writeData   <= 8'hFF;
                        state          <= S_UPD_DRE;
                    end else begin
                        word_q <= 1'b1;
                        state  <= S_CHECK;
                    end
                end
                S_UPD_DRE: begin
                    ri_writeEnable <= 1'b0;
                    done           <= 1'b1;
                    state          <= S_DONE;
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ri_refill.sv
// Directed bench for cache_ri_refill with flag-store, data-RAM and memory models.
module tb_cache_ri_refill;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic [AW-2:0] req_line;
    logic [1:0]    req_channel;
    logic [31:0]   req_memAddress;
    logic          busy;
    logic [AW-1:0] ri_readAddress;
    logic [1:0]    ri_readChannel;
    logic [7:0]    ri_readData;
    logic [AW-1:0] ri_writeAddress;
    logic [1:0]    ri_writeChannel;
    logic          ri_writeEnable;
    logic [7:0]    ri_writeData;
    logic [AW-1:0] dat_writeAddress;
    logic [1:0]    dat_writeChannel;
    logic [31:0]   dat_writeData;
    logic [3:0]    dat_writeByteEnable;
    logic          dat_writeEnable;
    logic [31:0]   mem_address;
    logic          mem_read;
    logic          mem_waitRequest;
    logic [31:0]   mem_readData;
    logic          mem_readDataValid;
    logic          done;

    cache_ri_refill #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_line(req_line),
        .req_channel(req_channel), .req_memAddress(req_memAddress), .busy(busy),
        .ri_readAddress(ri_readAddress), .ri_readChannel(ri_readChannel),
        .ri_readData(ri_readData), .ri_writeAddress(ri_writeAddress),
        .ri_writeChannel(ri_writeChannel), .ri_writeEnable(ri_writeEnable),
        .ri_writeData(ri_writeData), .dat_writeAddress(dat_writeAddress),
        .dat_writeChannel(dat_writeChannel), .dat_writeData(dat_writeData),
        .dat_writeByteEnable(dat_writeByteEnable), .dat_writeEnable(dat_writeEnable),
        .mem_address(mem_address), .mem_read(mem_read), .mem_waitRequest(mem_waitRequest),
        .mem_readData(mem_readData), .mem_readDataValid(mem_readDataValid), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  mask;
        logic [1:0]  ch;
        logic [7:0]  line;
        logic [31:0] addr;
        int          exp_reads;
        logic [31:0] exp_first;
        int          exp_wr;
        logic [3:0]  exp_be0;
        logic [3:0]  exp_be1;
        logic [31:0] exp_w0;
        logic [31:0] exp_w1;
        int          exp_lat;
    } vec_t;

    vec_t        vecs[6];
    logic [31:0] ram [4][512];
    logic [7:0]  flags [4][256];
    int          cyc = 0, accept_cyc = 0, done_cyc = 0;
    int          n_reads, n_wr, n_fw, n_done;
    logic [31:0] first_addr;
    logic [3:0]  be_seen [2];
    logic [7:0]  fw_data;
    logic        pend = 1'b0, mem_hold = 1'b0;
    logic [31:0] pend_addr;
    int          checks = 0, fails = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'hAABBCCDD;
            32'h104: return 32'h11223344;
            default: return {a[15:0], ~a[15:0]};
        endcase
    endfunction

    // Synchronous flag store: data appears one cycle after the address
    always @(posedge clk) ri_readData <= flags[ri_readChannel][ri_readAddress[AW-1:1]];

    // Memory responder plus observers for data RAM and flag writes
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend              = 1'b0;
            mem_readDataValid = 1'b0;
        end else begin
            mem_readDataValid = 1'b0;
            if (pend && !mem_hold) begin
                mem_readDataValid = 1'b1;
                mem_readData      = mem_word(pend_addr);
                pend              = 1'b0;
            end
            if (mem_read && !mem_waitRequest) begin
                pend      = 1'b1;
                pend_addr = mem_address;
                n_reads++;
                if (n_reads == 1) first_addr = mem_address;
            end
            if (dat_writeEnable) begin
                for (int b = 0; b < 4; b++)
                    if (dat_writeByteEnable[b])
                        ram[dat_writeChannel][dat_writeAddress][8*b +: 8] = dat_writeData[8*b +: 8];
                be_seen[dat_writeAddress[0]] = dat_writeByteEnable;
                n_wr++;
            end
            if (ri_writeEnable) begin
                flags[ri_writeChannel][ri_writeAddress[AW-1:1]] = ri_writeData;
                fw_data = ri_writeData;
                n_fw++;
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearCounters();
        n_reads    = 0;
        n_wr       = 0;
        n_fw       = 0;
        n_done     = 0;
        first_addr = '0;
        fw_data    = '0;
        be_seen[0] = '0;
        be_seen[1] = '0;
    endtask

    task automatic doRequest(input logic [7:0] line, input logic [1:0] ch, input logic [31:0] addr);
        int t;
        @(negedge clk);
        #1;
        t = 0;
        while (!req_ready && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!req_ready) checkOutput("req_ready_timeout", {31'd0, req_ready}, 32'd1);
        req_valid      = 1'b1;
        req_line       = line;
        req_channel    = ch;
        req_memAddress = addr;
        @(posedge clk);
        accept_cyc = cyc;
        #1 req_valid = 1'b0;
    endtask

    task automatic waitDone();
        int t;
        t = 0;
        while (n_done == 0 && t < 300) begin
            @(negedge clk);
            #1;
            t++;
        end
        checkOutput("done_seen", n_done, 1);
        @(negedge clk);
        #1;
        checkOutput("ready_after_done", {31'd0, req_ready}, 32'd1);
        checkOutput("done_one_cycle", {31'd0, done}, 32'd0);
    endtask

    task automatic applyStimulus(input int i);
        vec_t v;
        v = vecs[i];
        flags[v.ch][v.line]           = v.mask;
        ram[v.ch][{v.line, 1'b0}]     = 32'h55667788;
        ram[v.ch][{v.line, 1'b1}]     = 32'h55667788;
        clearCounters();
        doRequest(v.line, v.ch, v.addr);
        waitDone();
        checkOutput($sformatf("v%0d_reads", i), n_reads, v.exp_reads);
        checkOutput($sformatf("v%0d_first_addr", i), first_addr, v.exp_first);
        checkOutput($sformatf("v%0d_dat_writes", i), n_wr, v.exp_wr);
        checkOutput($sformatf("v%0d_be0", i), {28'd0, be_seen[0]}, {28'd0, v.exp_be0});
        checkOutput($sformatf("v%0d_be1", i), {28'd0, be_seen[1]}, {28'd0, v.exp_be1});
        checkOutput($sformatf("v%0d_word0", i), ram[v.ch][{v.line, 1'b0}], v.exp_w0);
        checkOutput($sformatf("v%0d_word1", i), ram[v.ch][{v.line, 1'b1}], v.exp_w1);
        checkOutput($sformatf("v%0d_flag_writes", i), n_fw, 1);
        checkOutput($sformatf("v%0d_flag_data", i), {24'd0, fw_data}, 32'hFF);
        checkOutput($sformatf("v%0d_flag_store", i), {24'd0, flags[v.ch][v.line]}, 32'hFF);
        checkOutput($sformatf("v%0d_latency", i), done_cyc - accept_cyc, v.exp_lat);
    endtask

    initial begin
        int t;
        vecs[0] = '{8'h00, 2'd2, 8'h10, 32'h100, 2, 32'h100, 2, 4'hF, 4'hF, 32'hAABBCCDD, 32'h11223344, 12};
        vecs[1] = '{8'h3C, 2'd1, 8'h21, 32'h100, 2, 32'h100, 2, 4'h3, 4'hC, 32'h5566CCDD, 32'h11227788, 12};
        vecs[2] = '{8'hFF, 2'd0, 8'h05, 32'h200, 0, 32'h0,   0, 4'h0, 4'h0, 32'h55667788, 32'h55667788, 6};
        vecs[3] = '{8'h0F, 2'd3, 8'hFF, 32'h100, 1, 32'h104, 1, 4'h0, 4'hF, 32'h55667788, 32'h11223344, 9};
        vecs[4] = '{8'hF0, 2'd0, 8'h00, 32'h100, 1, 32'h100, 1, 4'hF, 4'h0, 32'hAABBCCDD, 32'h55667788, 9};
        vecs[5] = '{8'h5A, 2'd2, 8'h77, 32'h100, 2, 32'h100, 2, 4'h5, 4'hA, 32'h55BB77DD, 32'h11663388, 12};

        for (int c = 0; c < 4; c++)
            for (int l = 0; l < 256; l++) flags[c][l] = 8'hFF;
        rst_n             = 1'b0;
        req_valid         = 1'b0;
        req_line          = '0;
        req_channel       = '0;
        req_memAddress    = '0;
        mem_waitRequest   = 1'b0;
        mem_readData      = '0;
        mem_readDataValid = 1'b0;
        clearCounters();

        #12;
        checkOutput("reset_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_strobes", {28'd0, done, mem_read, ri_writeEnable, dat_writeEnable}, 32'd0);
        checkOutput("reset_mem_address", mem_address, 32'd0);
        checkOutput("reset_ri_read_address", {23'd0, ri_readAddress}, 32'd0);
        #10 rst_n = 1'b1;

        for (int i = 0; i < 6; i++) applyStimulus(i);

        // Memory stall: request must hold steady while waitRequest is high
        $display("[TB] stall sequence");
        flags[2][8'h40]      = 8'h00;
        ram[2][{8'h40, 1'b0}] = 32'h55667788;
        ram[2][{8'h40, 1'b1}] = 32'h55667788;
        clearCounters();
        mem_waitRequest = 1'b1;
        doRequest(8'h40, 2'd2, 32'h200);
        t = 0;
        while (!mem_read && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        for (int k = 0; k < 5; k++) begin
            checkOutput($sformatf("stall_mem_read_%0d", k), {31'd0, mem_read}, 32'd1);
            checkOutput($sformatf("stall_mem_addr_%0d", k), mem_address, 32'h200);
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #1 mem_waitRequest = 1'b0;
        waitDone();
        checkOutput("stall_reads", n_reads, 2);
        checkOutput("stall_first_addr", first_addr, 32'h200);
        checkOutput("stall_word0", ram[2][{8'h40, 1'b0}], 32'h0200FDFF);
        checkOutput("stall_word1", ram[2][{8'h40, 1'b1}], 32'h0204FDFB);

        // Asynchronous reset while waiting for memory data
        $display("[TB] reset sequence");
        flags[1][8'h33] = 8'h00;
        clearCounters();
        mem_hold = 1'b1;
        doRequest(8'h33, 2'd1, 32'h100);
        t = 0;
        while (n_reads == 0 && t < 50) begin
            @(negedge clk);
            #1;
            t++;
        end
        checkOutput("rst_read_issued", n_reads, 1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_strobes", {28'd0, done, mem_read, ri_writeEnable, dat_writeEnable}, 32'd0);
        checkOutput("rst_mem_address", mem_address, 32'd0);
        checkOutput("rst_addresses", {ri_readAddress, ri_writeAddress, dat_writeAddress}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        mem_hold = 1'b0;
        checkOutput("rst_flags_untouched", {24'd0, flags[1][8'h33]}, 32'd0);
        applyStimulus(0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
